// File: rtl/jk_seq_pkg.sv
// Shared op encodings and controller states for the JK bank sequencer.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CLR    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_UP     = 3'd3,
    OP_DOWN   = 3'd4,
    OP_TOGGLE = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/jk_bank.sv
// Bank of behavioural JK flip-flops with asynchronous active-high clear.
// Pure storage: every J/K decision is made by the controller.
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // JK flop array: 00 hold, 01 reset, 10 set, 11 toggle
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          2'b01:   q[i] <= 1'b0;
          2'b10:   q[i] <= 1'b1;
          2'b11:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer driving a JK flip-flop bank (clear/load/toggle/count).
// Optional build macro JK_SEQ_SAT_EN: counting halts at the limits and raises sat.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  state_t           state_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [LEN_W-1:0] cnt_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             sat_r;

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic [WIDTH-1:0] up_mask_s;
  logic [WIDTH-1:0] dn_mask_s;
  logic             stop_s;

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .clear (clear),
    .j     (j_s),
    .k     (k_s),
    .q     (q_s)
  );

  // Synchronous-counter toggle enables: bit i flips when all lower bits are 1 (up) / 0 (down)
  always_comb begin
    logic up_c;
    logic dn_c;
    up_c = 1'b1;
    dn_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_mask_s[i] = up_c;
      dn_mask_s[i] = dn_c;
      up_c = up_c & q_s[i];
      dn_c = dn_c & ~q_s[i];
    end
  end

`ifdef JK_SEQ_SAT_EN
  // Limit reached: the current RUN edge ends the command instead of stepping
  always_comb begin
    if (op_r == OP_UP) begin
      stop_s = &q_s;
    end else begin
      stop_s = ~|q_s;
    end
  end
`else
  assign stop_s = 1'b0;
`endif

  // J/K decode; the bank holds (J=K=0) outside EXEC and RUN
  always_comb begin
    j_s = '0;
    k_s = '0;
    case (state_r)
      ST_EXEC: begin
        case (op_r)
          OP_CLR: begin
            j_s = '0;
            k_s = '1;
          end
          OP_LOAD: begin
            j_s = data_r;
            k_s = ~data_r;
          end
          OP_TOGGLE: begin
            j_s = data_r;
            k_s = data_r;
          end
          default: begin
            j_s = '0;
            k_s = '0;
          end
        endcase
      end
      ST_RUN: begin
        if (stop_s) begin
          j_s = '0;
          k_s = '0;
        end else if (op_r == OP_UP) begin
          j_s = up_mask_s;
          k_s = up_mask_s;
        end else begin
          j_s = dn_mask_s;
          k_s = dn_mask_s;
        end
      end
      default: begin
        j_s = '0;
        k_s = '0;
      end
    endcase
  end

  // Controller FSM; status outputs are registered alongside the state
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r <= ST_IDLE;
      op_r    <= 3'd0;
      data_r  <= '0;
      cnt_r   <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r    <= cmd_op;
            data_r  <= cmd_data;
            cnt_r   <= cmd_len;
            sat_r   <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            case (cmd_op)
              OP_CLR, OP_LOAD, OP_TOGGLE: begin
                state_r <= ST_EXEC;
              end
              OP_UP, OP_DOWN: begin
                if (cmd_len == {LEN_W{1'b0}}) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                end else begin
                  state_r <= ST_RUN;
                end
              end
              default: begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        ST_RUN: begin
          if (stop_s) begin
            cnt_r   <= '0;
            sat_r   <= 1'b1;
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - LEN_W'(1);
            if (cnt_r == LEN_W'(1)) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign q         = q_s;
  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign sat       = sat_r;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Self-checking bench for jk_seq_ctrl (WIDTH=4, LEN_W=4) against an arithmetic reference model.
module tb_jk_seq_ctrl;

  logic       clk;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_len;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       sat;

  int errors = 0;
  int checks = 0;
  logic [3:0] q_m;

  jk_seq_ctrl #(.WIDTH(4), .LEN_W(4)) dut (
    .clk       (clk),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .sat       (sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result of a command: final q, edges from accept to done visible, sat flag.
  function automatic void model(input logic [2:0] op, input logic [3:0] d, input int len,
                                input logic [3:0] q0, output logic [3:0] q1,
                                output int lat, output bit s);
    q1 = q0; s = 1'b0; lat = 1;
    case (op)
      3'd1: begin q1 = 4'd0; lat = 2; end
      3'd2: begin q1 = d; lat = 2; end
      3'd5: begin q1 = q0 ^ d; lat = 2; end
      3'd3, 3'd4: begin
        lat = len + 1;
        for (int i = 0; i < len; i++) begin
`ifdef JK_SEQ_SAT_EN
          if ((op == 3'd3 && q1 == 4'hF) || (op == 3'd4 && q1 == 4'h0)) begin
            s = 1'b1; lat = i + 2; break;
          end
`endif
          q1 = (op == 3'd3) ? q1 + 4'd1 : q1 - 4'd1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] d, input logic [3:0] len);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    clear = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0; cmd_len = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q: got %h required 0", q); end
    checks++; if (done !== 1'b0 || busy !== 1'b0 || sat !== 1'b0) begin
      errors++; $display("FAIL reset_flags: done=%b busy=%b sat=%b required 0 0 0", done, busy, sat); end
    clear = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    q_m = 4'h0;
  endtask

  task automatic test_load();
    int lat;
    send_cmd(3'd2, 4'hA, 4'd0);
    checks++; if (q !== q_m || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL load_exec: q=%h busy=%b ready=%b required q=%h busy=1 ready=0", q, busy, cmd_ready, q_m); end
    wait_done(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d required 2", lat); end
    checks++; if (q !== 4'hA) begin errors++; $display("FAIL load_q: got %h required a", q); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL load_after: done=%b ready=%b required 0 1", done, cmd_ready); end
    q_m = 4'hA;
  endtask

  task automatic test_count(input logic [2:0] op, input logic [3:0] init, input logic [3:0] len);
    int lat, lx;
    logic [3:0] qf, qx;
    bit s, sx;
    send_cmd(3'd2, init, 4'd0);
    wait_done(lat);
    @(posedge clk); #1;
    q_m = init;
    model(op, 4'd0, int'(len), q_m, qf, lat, s);
    send_cmd(op, 4'd0, len);
    for (int e = 1; e <= lat; e++) begin
      model(op, 4'd0, (e - 1 < int'(len)) ? e - 1 : int'(len), q_m, qx, lx, sx);
      checks++; if (q !== qx || done !== (e == lat)) begin
        errors++; $display("FAIL count_op%0d_edge%0d: q=%h done=%b required q=%h done=%b", op, e, q, done, qx, e == lat); end
      if (e < lat) begin @(posedge clk); #1; end
    end
    checks++; if (sat !== s) begin errors++; $display("FAIL count_sat: got %b required %b", sat, s); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL count_after: done=%b ready=%b required 0 1", done, cmd_ready); end
    q_m = qf;
  endtask

  task automatic test_toggle_len0();
    int lat;
    send_cmd(3'd2, 4'h3, 4'd0); wait_done(lat); @(posedge clk); #1;
    send_cmd(3'd5, 4'b0101, 4'd0); wait_done(lat);
    checks++; if (q !== 4'h6 || lat !== 2) begin
      errors++; $display("FAIL toggle: q=%h lat=%0d required 6 2", q, lat); end
    @(posedge clk); #1;
    send_cmd(3'd3, 4'd0, 4'd0); wait_done(lat);
    checks++; if (q !== 4'h6 || lat !== 1) begin
      errors++; $display("FAIL up_len0: q=%h lat=%0d required 6 1", q, lat); end
    @(posedge clk); #1;
    q_m = 4'h6;
  endtask

  task automatic test_clear_mid_run();
    int lat, dones;
    send_cmd(3'd2, 4'h5, 4'd0); wait_done(lat); @(posedge clk); #1;
    send_cmd(3'd3, 4'd0, 4'd8);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q !== 4'h8) begin errors++; $display("FAIL clr_pre: q=%h required 8", q); end
    #2 clear = 1'b1;
    #1;
    checks++; if (q !== 4'h0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_async: q=%h done=%b busy=%b required 0 0 0", q, done, busy); end
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || q !== 4'h0) begin
      errors++; $display("FAIL clr_release: ready=%b q=%h required 1 0", cmd_ready, q); end
    dones = 0;
    repeat (10) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL clr_no_done: got %0d dones required 0", dones); end
    q_m = 4'h0;
  endtask

  task automatic test_busy_ignore();
    int lat, n, dones;
    logic [3:0] qf;
    bit s;
    model(3'd3, 4'd0, 4, q_m, qf, lat, s);
    send_cmd(3'd3, 4'd0, 4'd4);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 4'hF; cmd_len = 4'd9;
    n = 1;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    cmd_valid = 1'b0;
    checks++; if (q !== qf || n !== lat) begin
      errors++; $display("FAIL busy_ignore: q=%h lat=%0d required %h %0d", q, n, qf, lat); end
    dones = 0;
    repeat (6) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    checks++; if (dones !== 0 || q !== qf) begin
      errors++; $display("FAIL busy_extra: dones=%0d q=%h required 0 %h", dones, q, qf); end
    q_m = qf;
  endtask

  task automatic test_random();
    int lat, elat;
    logic [2:0] op;
    logic [3:0] d, len, qf;
    bit s;
    for (int it = 0; it < 30; it++) begin
      op = 3'($urandom_range(0, 7));
      d = 4'($urandom);
      len = 4'($urandom_range(0, 6));
      model(op, d, int'(len), q_m, qf, elat, s);
      send_cmd(op, d, len);
      wait_done(lat);
      checks++; if (q !== qf || lat !== elat || sat !== s) begin
        errors++; $display("FAIL rand%0d_op%0d: q=%h lat=%0d sat=%b required %h %0d %b", it, op, q, lat, sat, qf, elat, s); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL rand%0d_after: done=%b ready=%b required 0 1", it, done, cmd_ready); end
      q_m = qf;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_count(3'd3, 4'hE, 4'd3);
    test_count(3'd4, 4'h2, 4'd2);
    test_count(3'd4, 4'h1, 4'd3);
    test_toggle_len0();
    test_clear_mid_run();
    test_busy_ignore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_seq_ctrl.md
JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of JK flip-flops in the controlled bank (2..16).
REQ-002 SHALL have parameter LEN_W, default 4: width of the count-length field.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: controller can accept a command.
REQ-007 SHALL have port cmd_op, input, 3: 0 NOP, 1 CLR, 2 LOAD, 3 UP, 4 DOWN, 5 TOGGLE; 6 and 7 are reserved.
REQ-008 SHALL have port cmd_data, input, WIDTH: LOAD value or TOGGLE mask.
REQ-009 SHALL have port cmd_len, input, LEN_W: number of count steps for UP/DOWN.
REQ-010 SHALL have port q, output, WIDTH: JK bank state.
REQ-011 SHALL have port busy, output, 1: command in progress (state is not IDLE).
REQ-012 SHALL have port done, output, 1: one-cycle pulse when a command completes.
REQ-013 SHALL have port sat, output, 1: saturation flag, meaningful only under JK_SEQ_SAT_EN.

Function
REQ-014 SHALL implement the FSM states IDLE, EXEC, RUN and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1, latching cmd_op, cmd_data and cmd_len.
REQ-016 SHALL, on accepting NOP or a reserved op, go IDLE->DONE and leave q unchanged.
REQ-017 SHALL, on accepting CLR, LOAD or TOGGLE, go IDLE->EXEC; the next edge applies J/K and goes to DONE.
REQ-018 SHALL drive J/K in EXEC as follows:
  - CLR: J=0, K=1 on all bits.
  - LOAD: J=d, K=~d.
  - TOGGLE: J=K=mask.
  - q therefore updates exactly one edge after EXEC is entered.
REQ-019 SHALL, on accepting UP or DOWN, go IDLE->RUN with the step counter loaded from cmd_len; if cmd_len=0, SHALL go directly to DONE with q unchanged.
REQ-020 SHALL apply one count step per edge in RUN using synchronous-counter JK drive:
  - UP: J_i=K_i=AND of q[i-1:0].
  - DOWN: J_i=K_i=AND of ~q[i-1:0].
  - bit 0 always toggles.
REQ-021 SHALL decrement the step counter on every RUN edge and leave RUN for DONE on the edge that applies the last step, so q changes exactly cmd_len times.
REQ-022 SHALL hold J=K=0 (q holds) in IDLE and DONE.
REQ-023 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE on the next edge.
REQ-024 SHALL ignore cmd_valid while busy; there is no command queue.

Reset
REQ-025 SHALL, while clear=1 (asynchronously), force q=0, state=IDLE, step counter=0, done=0 and sat=0.
REQ-026 SHALL abort a command in progress when clear is asserted, without producing a done pulse.
REQ-027 SHALL present cmd_ready=1 in the first cycle after clear deasserts.

Configuration
REQ-028 SHALL use the macro JK_SEQ_SAT_EN, with the following behaviour:
  - Defined: UP halts at all-ones and DOWN halts at all-zeros; on reaching the limit the remaining steps are skipped, the FSM goes to DONE, and sat is set (sticky until the next accept).
  - Not defined: counting wraps modulo 2^WIDTH and sat is tied 0.

Structure
REQ-029 SHALL define the op encodings and the FSM state enum in package jk_seq_pkg.
REQ-030 SHALL contain one sub-module, jk_bank: a WIDTH-wide array of behavioural JK flip-flops with async active-high clear, inputs j/k, output q.
REQ-031 SHALL keep all J/K decode logic in jk_seq_ctrl; jk_bank SHALL have no control logic.

Verification (WIDTH=4, LEN_W=4)
REQ-032 SHALL cover: LOAD data=4'hA -> q=4'hA one edge after EXEC; done pulse 1 cycle; cmd_ready returns the cycle after done.
REQ-033 SHALL cover: LOAD 4'hE, then UP len=3 -> q sequence F,0,1 without the macro; F then done early with sat=1 with the macro.
REQ-034 SHALL cover: LOAD 4'h2, then DOWN len=2 -> q=1 then 0; done on the cycle after the 2nd step.
REQ-035 SHALL cover: TOGGLE mask=4'b0101 from q=4'h3 -> q=4'h6; UP len=0 -> done with q unchanged.
REQ-036 SHALL cover: clear asserted mid-RUN (UP len=8, after 3 steps) -> q=0 immediately, no done pulse, cmd_ready=1 after release.
REQ-037 SHALL cover: cmd_valid held high during busy with other ops -> no extra accepts; exactly one done per accepted command.
